// File: rtl/threshold_event_monitor_if.sv
`default_nettype none
// ==== threshold_event_monitor_if : sample stream, controls and status bundle -- rev 1.0 ====
interface threshold_event_monitor_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic [WIDTH-1:0] thresh;
   logic             clear;
   logic             gt_flag;
   logic             alarm;
   logic [CNT_W-1:0] exceed_cnt;
   logic [WIDTH-1:0] max_val;
   logic             max_valid;

   modport master (
      output s_valid, s_data, thresh, clear,
      input  s_ready, gt_flag, alarm, exceed_cnt, max_val, max_valid
   );

   modport slave (
      input  s_valid, s_data, thresh, clear,
      output s_ready, gt_flag, alarm, exceed_cnt, max_val, max_valid
   );
endinterface
`default_nettype wire

// File: rtl/threshold_event_monitor.sv
`default_nettype none
// ==== threshold_event_monitor : debounced threshold alarm with count/max stats -- rev 1.0 ====
module threshold_event_monitor #(
   parameter int WIDTH    = 4,
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 8
) (
   input wire                       clk,
   input wire                       reset,
   threshold_event_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMING  = 2'd1,
      ALARM   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [3:0]       c_DEB     = 4'(DEBOUNCE);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic             a_valid_q;
   logic [WIDTH-1:0] a_data_q;
   logic [WIDTH-1:0] a_thresh_q;

   state_t           state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic             gt_flag_q, gt_flag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic             max_valid_q, max_valid_d;

   logic             w_gt;
   logic [4:0]       w_run_inc;
   logic             w_run_done;

   assign bus.s_ready = ~bus.clear;

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         a_valid_q <= 1'b0;
      end else begin
         a_valid_q <= bus.s_valid & bus.s_ready;
      end
      if (bus.s_valid && bus.s_ready) begin
         a_data_q   <= bus.s_data;
         a_thresh_q <= bus.thresh;
      end
   end

   assign w_gt       = (a_data_q > a_thresh_q);
   assign w_run_inc  = {1'b0, run_q} + 5'd1;
   assign w_run_done = (w_run_inc >= {1'b0, c_DEB});

   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      gt_flag_d   = gt_flag_q;
      cnt_d       = cnt_q;
      max_d       = max_q;
      max_valid_d = max_valid_q;
      if (a_valid_q) begin
         gt_flag_d   = w_gt;
         max_valid_d = 1'b1;
         if (w_gt && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (!max_valid_q || (a_data_q > max_q)) begin
            max_d = a_data_q;
         end
         // run counts consecutive samples that argue for leaving the current level
         case (state_q)
            IDLE: begin
               run_d = 4'd0;
               if (w_gt) begin
                  if (c_DEB == 4'd1) begin
                     state_d = ALARM;
                  end else begin
                     state_d = ARMING;
                     run_d   = 4'd1;
                  end
               end
            end
            ARMING: begin
               if (!w_gt) begin
                  state_d = IDLE;
                  run_d   = 4'd0;
               end else if (w_run_done) begin
                  state_d = ALARM;
                  run_d   = 4'd0;
               end else begin
                  run_d = w_run_inc[3:0];
               end
            end
            ALARM: begin
               run_d = 4'd0;
               if (!w_gt) begin
                  if (c_DEB == 4'd1) begin
                     state_d = IDLE;
                  end else begin
                     state_d = RELEASE;
                     run_d   = 4'd1;
                  end
               end
            end
            RELEASE: begin
               if (w_gt) begin
                  state_d = ALARM;
                  run_d   = 4'd0;
               end else if (w_run_done) begin
                  state_d = IDLE;
                  run_d   = 4'd0;
               end else begin
                  run_d = w_run_inc[3:0];
               end
            end
            default: begin
               state_d = IDLE;
               run_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         state_q     <= IDLE;
         run_q       <= 4'd0;
         gt_flag_q   <= 1'b0;
         cnt_q       <= '0;
         max_q       <= '0;
         max_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         gt_flag_q   <= gt_flag_d;
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         max_valid_q <= max_valid_d;
      end
   end

   assign bus.gt_flag    = gt_flag_q;
   assign bus.alarm      = (state_q == ALARM) || (state_q == RELEASE);
   assign bus.exceed_cnt = cnt_q;
   assign bus.max_val    = max_q;
   assign bus.max_valid  = max_valid_q;

endmodule
`default_nettype wire
